// File: rtl/esc_pkg.sv
// Shared constants and FSM encoding for the 8086 ESC (FPU) instruction
// encoder and its decoder counterpart.
package esc_pkg;

  // High five bits of every ESC opcode byte (D8..DF).
  localparam logic [4:0] ESC_PREFIX   = 5'b11011;
  // FWAIT instruction byte, optionally emitted ahead of the opcode.
  localparam logic [7:0] FWAIT_OPCODE = 8'h9B;
  // ModR/M.mod value selecting a register operand (ST(i)); no displacement.
  localparam logic [1:0] MOD_REG      = 2'b11;
  // ModR/M.rm value that, with mod=00, means a 16-bit direct address.
  localparam logic [2:0] RM_DIRECT    = 3'b110;

  // Byte-emission states; the decoder tracks the same sequence.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX   = 3'd1,
    OPC   = 3'd2,
    MODRM = 3'd3,
    DLO   = 3'd4,
    DHI   = 3'd5
  } esc_state_e;

endpackage

// File: rtl/esc_disp_len.sv
// Displacement byte count implied by ModR/M {mod, rm}.
module esc_disp_len
  import esc_pkg::*;
(
  input  logic [1:0] mod_i,
  input  logic [2:0] rm_i,
  output logic [1:0] count_o
);

  // Map the addressing mode onto 0, 1 or 2 trailing displacement bytes.
  always_comb begin
    count_o = 2'd0;
    case (mod_i)
      MOD_REG: count_o = 2'd0;
      2'b00:   count_o = (rm_i == RM_DIRECT) ? 2'd2 : 2'd0;
      2'b01:   count_o = 2'd1;
      default: count_o = 2'd2;
    endcase
  end

endmodule

// File: rtl/esc_encoder.sv
// Serialises an FPU request into the ESC byte stream:
// [FWAIT] opcode ModR/M [disp lo] [disp hi], one byte per valid/ready beat.
// Optional feature: ESC_ENCODER_FWAIT_PREFIX_EN enables the 9B prefix on req_wait.
module esc_encoder
  import esc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_esc_index,
  input  logic [2:0]  req_fpu_opcode,
  input  logic [1:0]  req_mod,
  input  logic [2:0]  req_rm,
  input  logic [15:0] req_disp,
  input  logic        req_wait,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_first,
  output logic        byte_last,
  output logic        busy
);

  esc_state_e  state_q, state_d;
  logic [2:0]  esc_q, esc_d;
  logic [2:0]  fop_q, fop_d;
  logic [1:0]  mod_q, mod_d;
  logic [2:0]  rm_q, rm_d;
  logic [15:0] disp_q, disp_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        hs;
  logic        accept;

`ifndef ESC_ENCODER_FWAIT_PREFIX_EN
  // Without the prefix feature the wait request has no effect.
  logic unused_wait;
  assign unused_wait = req_wait;
`endif

  // Displacement count of whichever instruction the next-state fields hold.
  esc_disp_len u_disp_len (
    .mod_i   (mod_d),
    .rm_i    (rm_d),
    .count_o (cnt_d)
  );

  assign hs         = valid_q && byte_ready;
  // Accept in IDLE, or on the final-byte handshake for back-to-back issue.
  assign req_ready  = (state_q == IDLE) || (hs && last_q);
  assign accept     = req_valid && req_ready;
  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign byte_first = first_q;
  assign byte_last  = last_q;
  assign busy       = (state_q != IDLE);

  // Next state, field capture and the byte to present in the next state.
  always_comb begin
    state_d = state_q;
    esc_d   = esc_q;
    fop_d   = fop_q;
    mod_d   = mod_q;
    rm_d    = rm_q;
    disp_d  = disp_q;
    if (hs) begin
      case (state_q)
`ifdef ESC_ENCODER_FWAIT_PREFIX_EN
        PFX:     state_d = OPC;
`endif
        OPC:     state_d = MODRM;
        MODRM:   state_d = (cnt_q == 2'd0) ? IDLE : DLO;
        DLO:     state_d = (cnt_q == 2'd1) ? IDLE : DHI;
        DHI:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      esc_d   = req_esc_index;
      fop_d   = req_fpu_opcode;
      mod_d   = req_mod;
      rm_d    = req_rm;
      disp_d  = req_disp;
`ifdef ESC_ENCODER_FWAIT_PREFIX_EN
      state_d = req_wait ? PFX : OPC;
`else
      state_d = OPC;
`endif
    end

    // The first byte of an instruction is only ever entered via acceptance.
    valid_d = (state_d != IDLE);
    first_d = accept;
    last_d  = 1'b0;
    data_d  = 8'h00;
    case (state_d)
`ifdef ESC_ENCODER_FWAIT_PREFIX_EN
      PFX:     data_d = FWAIT_OPCODE;
`endif
      OPC:     data_d = {ESC_PREFIX, esc_d};
      MODRM: begin
        data_d = {mod_d, fop_d, rm_d};
        last_d = (cnt_d == 2'd0);
      end
      DLO: begin
        data_d = disp_d[7:0];
        last_d = (cnt_d == 2'd1);
      end
      DHI: begin
        data_d = disp_d[15:8];
        last_d = 1'b1;
      end
      default: data_d = 8'h00;
    endcase
  end

  // State, holding and output registers; reset discards any partial instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      esc_q   <= 3'd0;
      fop_q   <= 3'd0;
      mod_q   <= 2'd0;
      rm_q    <= 3'd0;
      disp_q  <= 16'h0000;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      esc_q   <= esc_d;
      fop_q   <= fop_d;
      mod_q   <= mod_d;
      rm_q    <= rm_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_esc_encoder.sv
// Directed bench for esc_encoder; expected bytes are hand-encoded ESC forms.
module tb_esc_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_esc_index;
  logic [2:0]  req_fpu_opcode;
  logic [1:0]  req_mod;
  logic [2:0]  req_rm;
  logic [15:0] req_disp;
  logic        req_wait;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_first;
  logic        byte_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  esc_encoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_esc_index  (req_esc_index),
    .req_fpu_opcode (req_fpu_opcode),
    .req_mod        (req_mod),
    .req_rm         (req_rm),
    .req_disp       (req_disp),
    .req_wait       (req_wait),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .byte_data      (byte_data),
    .byte_first     (byte_first),
    .byte_last      (byte_last),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] e, input logic [2:0] f, input logic [1:0] m,
                       input logic [2:0] r, input logic [15:0] d, input logic w);
    req_esc_index  = e;
    req_fpu_opcode = f;
    req_mod        = m;
    req_rm         = r;
    req_disp       = d;
    req_wait       = w;
    req_valid      = 1'b1;
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] d, input logic f, input logic l);
    #1;
    chk({tag, ".valid"}, {15'd0, byte_valid}, 16'd1);
    chk({tag, ".data"},  {8'd0, byte_data},   {8'd0, d});
    chk({tag, ".first"}, {15'd0, byte_first}, {15'd0, f});
    chk({tag, ".last"},  {15'd0, byte_last},  {15'd0, l});
    $display("byte %s data=%h first=%0b last=%0b", tag, byte_data, byte_first, byte_last);
  endtask

  task automatic exp_idle(input string tag);
    #1;
    chk({tag, ".valid"}, {15'd0, byte_valid}, 16'd0);
    chk({tag, ".busy"},  {15'd0, busy},       16'd0);
  endtask

  logic [7:0] stall_exp [4];
  bit         rdy_pat [12];
  int         idx;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_esc_index = '0; req_fpu_opcode = '0;
    req_mod = '0; req_rm = '0; req_disp = '0; req_wait = 1'b0; byte_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst.valid", {15'd0, byte_valid}, 16'd0);
    chk("rst.data",  {8'd0, byte_data},   16'd0);
    chk("rst.first", {15'd0, byte_first}, 16'd0);
    chk("rst.last",  {15'd0, byte_last},  16'd0);
    chk("rst.busy",  {15'd0, busy},       16'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk("rst.req_ready", {15'd0, req_ready}, 16'd1);

    // Register form: FLD ST(2) style, D9 C2.
    issue(3'd1, 3'd0, 2'b11, 3'd2, 16'h0000, 1'b0);
    #1 chk("t1.req_ready", {15'd0, req_ready}, 16'd1);
    step(); req_valid = 1'b0;
    exp_byte("t1.b0", 8'hD9, 1'b1, 1'b0);
    step();
    exp_byte("t1.b1", 8'hC2, 1'b0, 1'b1);
    chk("t1.ready_on_last", {15'd0, req_ready}, 16'd1);
    step();
    exp_idle("t1.end");

    // Direct address: DD 3E 34 12.
    issue(3'd5, 3'd7, 2'b00, 3'b110, 16'h1234, 1'b0);
    step(); req_valid = 1'b0;
    exp_byte("t2.b0", 8'hDD, 1'b1, 1'b0); step();
    exp_byte("t2.b1", 8'h3E, 1'b0, 1'b0); step();
    exp_byte("t2.b2", 8'h34, 1'b0, 1'b0); step();
    exp_byte("t2.b3", 8'h12, 1'b0, 1'b1); step();
    exp_idle("t2.end");

    // 8-bit displacement: D8 47 80.
    issue(3'd0, 3'd0, 2'b01, 3'd7, 16'hFF80, 1'b0);
    step(); req_valid = 1'b0;
    exp_byte("t3.b0", 8'hD8, 1'b1, 1'b0); step();
    exp_byte("t3.b1", 8'h47, 1'b0, 1'b0); step();
    exp_byte("t3.b2", 8'h80, 1'b0, 1'b1); step();
    exp_idle("t3.end");

    // 16-bit displacement: D8 87 CD AB.
    issue(3'd0, 3'd0, 2'b10, 3'd7, 16'hABCD, 1'b0);
    step(); req_valid = 1'b0;
    exp_byte("t4.b0", 8'hD8, 1'b1, 1'b0); step();
    exp_byte("t4.b1", 8'h87, 1'b0, 1'b0); step();
    exp_byte("t4.b2", 8'hCD, 1'b0, 1'b0); step();
    exp_byte("t4.b3", 8'hAB, 1'b0, 1'b1); step();
    exp_idle("t4.end");

    // Stalls during DD 3E 34 12: outputs must hold while byte_ready is low.
    stall_exp[0] = 8'hDD; stall_exp[1] = 8'h3E; stall_exp[2] = 8'h34; stall_exp[3] = 8'h12;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    issue(3'd5, 3'd7, 2'b00, 3'b110, 16'h1234, 1'b0);
    step(); req_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      byte_ready = rdy_pat[c];
      exp_byte($sformatf("t5.c%0d", c), stall_exp[idx], idx == 0, idx == 3);
      chk($sformatf("t5.c%0d.busy", c), {15'd0, busy}, 16'd1);
      if (!rdy_pat[c])
        chk($sformatf("t5.c%0d.req_ready", c), {15'd0, req_ready}, 16'd0);
      step();
      if (rdy_pat[c]) idx++;
    end
    chk("t5.all_bytes", idx[15:0], 16'd4);
    byte_ready = 1'b1;
    exp_idle("t5.end");

    // Back-to-back: D9 C2 then DB D5 with no gap.
    issue(3'd1, 3'd0, 2'b11, 3'd2, 16'h0000, 1'b0);
    step();
    issue(3'd3, 3'd2, 2'b11, 3'd5, 16'h0000, 1'b0);
    exp_byte("t6.a0", 8'hD9, 1'b1, 1'b0);
    chk("t6.stall_ready", {15'd0, req_ready}, 16'd0);
    step();
    exp_byte("t6.a1", 8'hC2, 1'b0, 1'b1);
    chk("t6.ready_on_last", {15'd0, req_ready}, 16'd1);
    step(); req_valid = 1'b0;
    exp_byte("t6.b0", 8'hDB, 1'b1, 1'b0); step();
    exp_byte("t6.b1", 8'hD5, 1'b0, 1'b1); step();
    exp_idle("t6.end");

    // Reset while presenting the low displacement byte.
    issue(3'd0, 3'd0, 2'b10, 3'd7, 16'hABCD, 1'b0);
    step(); req_valid = 1'b0;
    step(); step();
    exp_byte("t7.dlo", 8'hCD, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t7.rst.valid", {15'd0, byte_valid}, 16'd0);
    chk("t7.rst.busy",  {15'd0, busy},       16'd0);
    chk("t7.rst.data",  {8'd0, byte_data},   16'd0);
    step();
    reset_n = 1'b1;
    step();
    exp_idle("t7.after");

    // Wait request: prefix only when the feature is compiled in.
    issue(3'd1, 3'd0, 2'b11, 3'd2, 16'h0000, 1'b1);
    step(); req_valid = 1'b0;
`ifdef ESC_ENCODER_FWAIT_PREFIX_EN
    exp_byte("t8.pfx", 8'h9B, 1'b1, 1'b0); step();
    exp_byte("t8.b0", 8'hD9, 1'b0, 1'b0); step();
`else
    exp_byte("t8.b0", 8'hD9, 1'b1, 1'b0); step();
`endif
    exp_byte("t8.b1", 8'hC2, 1'b0, 1'b1); step();
    exp_idle("t8.end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
